lzc_scan: RTL and testbench
===========================

# lzc_scan

Parametrised, multi-mode, multi-bit-per-cycle sequential leading/trailing bit counter. It generalises the 64-bit, one-bit-per-cycle leading-zero detector in the arithmetic-logical-units group. The block counts leading or trailing zeros or ones of a WIDTH-bit operand, examining CHUNK bits per cycle, with an abort input. It serves as the normalisation-count engine for shifters and FP pre-normalisers where area matters more than single-cycle latency.

## Interface
- WIDTH, 64: operand width; must be a multiple of CHUNK.
- CHUNK, 4: bits examined per SCAN cycle; 1 ≤ CHUNK ≤ WIDTH.
- CNT_W, derived localparam = $clog2(WIDTH+1): result width; not overridable.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0 and abort=0.
- abort  in  1  cancels an operation in progress.
- mode  in  2  0 = leading zeros, 1 = leading ones, 2 = trailing zeros, 3 = trailing ones; sampled with start.
- data_in  in  WIDTH  operand; sampled with start.
- count  out  CNT_W  result; range 0..WIDTH.
- all_match  out  1  set when no terminating bit exists (count = WIDTH).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when count/all_match update.

## Operation
- States: IDLE and SCAN (shared package enum). Reset → IDLE.
- Accept (IDLE, start=1, abort=0):
  - Latch mode and a normalised copy of data_in into the scan register.
  - Trailing modes bit-reverse the operand; ones modes invert it. Every mode then reduces to a leading-zero scan.
  - Clear the accumulator and chunk index. Go to SCAN.
- SCAN, each cycle, examines the top CHUNK bits of the scan register:
  - If all are zero and the chunk index < WIDTH/CHUNK−1: accumulator += CHUNK, shift left by CHUNK, index += 1.
  - If any is one: count ← accumulator + in-chunk leading zeros, all_match ← 0, done ← 1, go to IDLE.
  - If all are zero on the last chunk: count ← WIDTH, all_match ← 1, done ← 1, go to IDLE.
- Abort in SCAN: go to IDLE at the next edge. busy ← 0, no done. count and all_match keep their previous values.
- Abort in IDLE: start is ignored that cycle.
- start while busy=1 is ignored. There is no queueing.
- count and all_match hold the last completed result. They are not cleared on start.
- The accumulator is CNT_W bits and never exceeds WIDTH, so no overflow handling is needed.

## Timing
- Reset values: count=0, all_match=0, busy=0, done=0, state=IDLE. Reset mid-SCAN discards the operation with no done.
- Let start be accepted at edge T, and let i be the 0-based chunk index holding the first terminating bit.
- Cycles T+1..T+1+i are SCAN with busy=1.
- In cycle T+2+i: done=1, busy=0, and count/all_match are valid.
- Start-to-done latency is i+2 cycles. The worst case (all_match) is WIDTH/CHUNK+1.
- Back-to-back: a start in the done cycle is accepted, since busy=0.
- done is high for exactly one cycle.

## Structure
- Package lzc_pkg:
  - mode encodings (LZ, LO, TZ, TO);
  - the state enum;
  - a function computing the count width from WIDTH.
- One sub-module, lzc_chunk_enc: combinational CHUNK-bit priority encoder.
  - Outputs any_one and the in-chunk leading-zero count ($clog2(CHUNK+1) bits).
  - Instantiated once on the top CHUNK bits of the scan register.
- The top level holds the FSM, normalisation (reverse/invert), the scan shift register, the accumulator and the chunk index.

## Test plan
All scenarios use WIDTH=64, CHUNK=4.
- mode=0, data_in=0x0000_0100_0000_0000 (bit 40) → count=23, all_match=0, done 7 cycles after start, busy high for 6 cycles.
- mode=0, data_in=0 → count=64, all_match=1, done 17 cycles after start; start pulses during busy are ignored.
- mode=3, data_in=0x0000_0000_0000_00FF → count=8, done 4 cycles after start. Then mode=2, data_in=0x8000_0000_0000_0000 → count=63.
- mode=1, data_in=0xFFFF_FFFF_FFFF_FFFF → count=64, all_match=1. Then mode=1, data_in=0x7FFF_FFFF_FFFF_FFFF → count=0, all_match=0, done 2 cycles after start.
- Prior result count=8. Start mode=0, data_in=0, abort on the 3rd SCAN cycle → busy=0 next cycle, no done, count stays 8. Then start with data_in=0x8000_0000_0000_0000 → count=0.
- Assert rst mid-SCAN → all outputs 0 the next cycle. A start issued in a done cycle is accepted with busy=1 the following cycle.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared types and constants for the sequential leading/trailing bit counter.
// Mode encodings, scan FSM states and the result-width helper.
package lzc_pkg;

   localparam logic [1:0] MODE_LZ = 2'd0;
   localparam logic [1:0] MODE_LO = 2'd1;
   localparam logic [1:0] MODE_TZ = 2'd2;
   localparam logic [1:0] MODE_TO = 2'd3;

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/lzc_chunk_enc.sv
// Combinational priority encoder for one chunk of the scan register.
// Reports whether any bit is set and how many leading zeros precede it.
module lzc_chunk_enc #(
   parameter  int CHUNK = 4,
   localparam int LZ_W  = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] bits,
   output logic             any_one,
   output logic [LZ_W-1:0]  lz
);

   // Highest set bit wins because it is visited last
   always_comb begin
      any_one = |bits;
      lz      = LZ_W'(CHUNK);
      for (int k = 0; k < CHUNK; k++) begin
         if (bits[k]) lz = LZ_W'(CHUNK - 1 - k);
      end
   end

endmodule

// File: rtl/lzc_scan.sv
// Multi-mode sequential leading/trailing zero/one counter.
// Operand is normalised once, then scanned CHUNK bits per cycle from the top.
module lzc_scan
   import lzc_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int CHUNK = 4,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   output logic [CNT_W-1:0] count,
   output logic             all_match,
   output logic             busy,
   output logic             done
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int LZ_W   = $clog2(CHUNK + 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] scan_q;
   logic [WIDTH-1:0] norm;
   logic [CNT_W-1:0] acc_q;
   logic [IDX_W-1:0] idx_q;
   logic             any_one;
   logic [LZ_W-1:0]  chunk_lz;
   logic             last;
   logic             accept;
   logic             step;
   logic             hit;
   logic             exhaust;

   lzc_chunk_enc #(.CHUNK(CHUNK)) u_enc (
      .bits    (scan_q[WIDTH-1 -: CHUNK]),
      .any_one (any_one),
      .lz      (chunk_lz)
   );

   assign last = (idx_q == IDX_W'(NCHUNK - 1));
   assign busy = (state_q == SCAN);

   // Reverse for trailing modes, invert for ones modes
   always_comb begin
      norm = data_in;
      if (mode == MODE_TZ || mode == MODE_TO) begin
         for (int k = 0; k < WIDTH; k++) norm[k] = data_in[WIDTH-1-k];
      end
      if (mode == MODE_LO || mode == MODE_TO) norm = ~norm;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle scan decision; abort beats completion
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      hit     = 1'b0;
      exhaust = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               accept  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (any_one) begin
               hit     = 1'b1;
               state_d = IDLE;
            end else if (last) begin
               exhaust = 1'b1;
               state_d = IDLE;
            end else begin
               step = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan shifter, accumulator, chunk index and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         count     <= '0;
         all_match <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= hit | exhaust;
         if (accept) begin
            scan_q <= norm;
            acc_q  <= '0;
            idx_q  <= '0;
         end else if (step) begin
            scan_q <= scan_q << CHUNK;
            acc_q  <= acc_q + CNT_W'(CHUNK);
            idx_q  <= idx_q + 1'b1;
         end
         if (hit) begin
            count     <= acc_q + CNT_W'(chunk_lz);
            all_match <= 1'b0;
         end else if (exhaust) begin
            count     <= CNT_W'(WIDTH);
            all_match <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lzc_scan.sv
// Self-checking bench for lzc_scan with WIDTH=64, CHUNK=4.
// Expected results are queued at issue time and popped when done fires.
module tb_lzc_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [63:0] data_in;
   logic [6:0]  count;
   logic        all_match;
   logic        busy;
   logic        done;

   typedef struct {
      int cnt;
      bit all;
      int lat;
      int bsy;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lzc_scan #(.WIDTH(64), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .data_in   (data_in),
      .count     (count),
      .all_match (all_match),
      .busy      (busy),
      .done      (done)
   );

   task automatic issue(input logic [1:0] m, input logic [63:0] d,
                        input int c, input bit a, input int l, input bit push);
      exp_t e;
      e.cnt = c; e.all = a; e.lat = l; e.bsy = l - 1;
      if (push) sb.push_back(e);
      mode = m; data_in = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; data_in = '0;
   endtask

   task automatic wait_done(input int junk, output int lat,
                            output int bsy, output bit ok);
      lat = 1; bsy = 0; ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (busy) bsy++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
         if (junk > 0 && lat <= junk + 1) begin
            start = 1'b1; mode = 2'd1; data_in = '0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; data_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (all_match !== 1'b0) begin failures++; $display("FAIL reset_all got=%b exp=0", all_match); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      @(posedge clk); #1;
   endtask

   task automatic test_lz_bit40();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd0, 64'h0000_0100_0000_0000, 23, 1'b0, 7, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL lz40_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL lz40_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL lz40_all got=%b exp=%b", all_match, e.all); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL lz40_latency got=%0d exp=%0d", lat, e.lat); end
      checks++; if (bsy != e.bsy) begin failures++; $display("FAIL lz40_busy got=%0d exp=%0d", bsy, e.bsy); end
   endtask

   task automatic test_all_zero();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd0, 64'h0, 64, 1'b1, 17, 1'b1);
      wait_done(3, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL zero_all got=%b exp=%b", all_match, e.all); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, e.lat); end
      checks++; if (bsy != e.bsy) begin failures++; $display("FAIL zero_busy got=%0d exp=%0d", bsy, e.bsy); end
      @(posedge clk); #1;
   endtask

   task automatic test_trailing();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd3, 64'h0000_0000_0000_00FF, 8, 1'b0, 4, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL to_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL to_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", lat, e.lat); end
      @(posedge clk); #1;
      issue(2'd2, 64'h8000_0000_0000_0000, 63, 1'b0, 17, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL tz_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL tz_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL tz_all got=%b exp=%b", all_match, e.all); end
      @(posedge clk); #1;
   endtask

   task automatic test_leading_ones();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 17, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL lo_full_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL lo_full_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL lo_full_all got=%b exp=%b", all_match, e.all); end
      @(posedge clk); #1;
      issue(2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1'b0, 2, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL lo_zero_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL lo_zero_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL lo_zero_all got=%b exp=%b", all_match, e.all); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL lo_zero_latency got=%0d exp=%0d", lat, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int lat, bsy; bit ok, seen; exp_t e;
      issue(2'd3, 64'h0000_0000_0000_00FF, 8, 1'b0, 4, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL ab_prior_count got=%0d exp=%0d", count, e.cnt); end
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; mode = 2'd0; data_in = '0;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_idle_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
      issue(2'd0, 64'h0, 64, 1'b1, 17, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", busy); end
      checks++; if (count !== 7'd8) begin failures++; $display("FAIL ab_count got=%0d exp=8", count); end
      checks++; if (all_match !== 1'b0) begin failures++; $display("FAIL ab_all got=%b exp=0", all_match); end
      seen = done;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++; if (seen) begin failures++; $display("FAIL ab_no_done got=1 exp=0"); end
      @(posedge clk); #1;
      issue(2'd0, 64'h8000_0000_0000_0000, 0, 1'b0, 2, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL ab_after_timeout got=none exp=done"); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL ab_after_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL ab_after_latency got=%0d exp=%0d", lat, e.lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_scan();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd0, 64'h0, 64, 1'b1, 17, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (all_match !== e.all) begin failures++; $display("FAIL rm_prior_all got=%b exp=%b", all_match, e.all); end
      @(posedge clk); #1;
      issue(2'd0, 64'h0, 64, 1'b1, 17, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (count !== 7'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", count); end
      checks++; if (all_match !== 1'b0) begin failures++; $display("FAIL rm_all got=%b exp=0", all_match); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", done); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat, bsy; bit ok; exp_t e;
      issue(2'd0, 64'h0000_0100_0000_0000, 23, 1'b0, 7, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL b2b_a_count got=%0d exp=%0d", count, e.cnt); end
      issue(2'd2, 64'h0000_0000_0000_0008, 3, 1'b0, 2, 1'b1);
      wait_done(0, lat, bsy, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin failures++; $display("FAIL b2b_b_timeout got=none exp=done"); end
      checks++; if (bsy != e.bsy) begin failures++; $display("FAIL b2b_b_busy got=%0d exp=%0d", bsy, e.bsy); end
      checks++; if (count !== 7'(e.cnt)) begin failures++; $display("FAIL b2b_b_count got=%0d exp=%0d", count, e.cnt); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_b_latency got=%0d exp=%0d", lat, e.lat); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%b exp=0", done); end
   endtask

   initial begin
      test_reset();
      test_lz_bit40();
      test_all_zero();
      test_trailing();
      test_leading_ones();
      test_abort();
      test_reset_mid_scan();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
